// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the clk_pll_0 lock supervisor: 3-bit state encodings,
// the registered output bundle and its decode, and the counter-width helper.
package pll_lock_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_PWD       = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } supv_state_e;

    typedef struct packed {
        logic pll_pwd;
        logic pll_rst;
        logic sys_rst;
        logic pll_ok;
        logic lock_fail;
        logic lock_lost;
    } supv_out_t;

    localparam supv_out_t SUPV_OUT_RST = supv_out_t'(6'b111000);

    function automatic int clog2_w(input int v);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < v) w = i + 1;
        return w;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Outputs are a pure function of the state being entered plus the loss event.
    function automatic supv_out_t supv_decode(input supv_state_e s, input logic lost);
        supv_out_t o;
        o.pll_pwd   = (s == ST_PWD) || (s == ST_FAIL);
        o.pll_rst   = (s == ST_PWD) || (s == ST_RST) || (s == ST_FAIL);
        o.sys_rst   = (s != ST_RUN);
        o.pll_ok    = (s == ST_RUN);
        o.lock_fail = (s == ST_FAIL);
        o.lock_lost = lost;
        return o;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, cleared by rst.
module sync_2ff (
    input  logic clkin1,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clkin1) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL power-up/lock supervisor on clkin1: sequences pll_pwd/pll_rst, qualifies lock,
// retries on timeout. Define PLL_SUPV_LOSS_CNT_EN to add the loss_cnt output.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int PWD_CYCLES          = 3,
    parameter int RST_CYCLES          = 3,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 2500,
    parameter int MAX_RETRY           = 3
) (
    input  logic       clkin1,
    input  logic       rst,
    input  logic       lock,
    input  logic       restart,
    output logic       pll_pwd,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       pll_ok,
    output logic       lock_fail,
    output logic       lock_lost,
`ifdef PLL_SUPV_LOSS_CNT_EN
    output logic [7:0] loss_cnt,
`endif
    output logic [1:0] retry_cnt
);
    localparam int TMAX = max_of(max_of(PWD_CYCLES, RST_CYCLES),
                                 max_of(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES));
    localparam int TW = clog2_w(TMAX);

    localparam logic [TW-1:0] PWD_LAST = TW'(PWD_CYCLES - 1);
    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    supv_state_e   state, nxt;
    logic [TW-1:0] timer;
    logic [1:0]    retry_nxt;
    logic          lost_evt;
    logic          lock_s;
    supv_out_t     out_q;

    sync_2ff u_lock_sync (
        .clkin1 (clkin1),
        .rst    (rst),
        .d      (lock),
        .q      (lock_s)
    );

    always_comb begin
        nxt       = state;
        retry_nxt = retry_cnt;
        lost_evt  = 1'b0;
        if (restart) begin
            nxt       = ST_PWD;
            retry_nxt = 2'd0;
        end else begin
            case (state)
                ST_PWD:       if (timer == PWD_LAST) nxt = ST_RST;
                ST_RST:       if (timer == RST_LAST) nxt = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        nxt = ST_STABLE;
                    end else if (timer == TO_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            nxt = ST_FAIL;
                        end else begin
                            nxt       = ST_PWD;
                            retry_nxt = retry_cnt + 2'd1;
                        end
                    end
                end
                // A dropout while qualifying reopens the timeout window without costing a retry.
                ST_STABLE: begin
                    if (!lock_s)
                        nxt = ST_WAIT_LOCK;
                    else if (timer == STB_LAST)
                        nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        nxt       = ST_PWD;
                        retry_nxt = 2'd0;
                        lost_evt  = 1'b1;
                    end
                end
                ST_FAIL:  nxt = ST_FAIL;
                default:  nxt = ST_PWD;
            endcase
        end
    end

    always_ff @(posedge clkin1) begin
        if (rst) begin
            state     <= ST_PWD;
            timer     <= '0;
            retry_cnt <= 2'd0;
            out_q     <= SUPV_OUT_RST;
        end else begin
            state     <= nxt;
            retry_cnt <= retry_nxt;
            out_q     <= supv_decode(nxt, lost_evt);
            // restart must also clear the timer when it re-enters PWD from PWD
            if (restart || (nxt != state))
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

    assign pll_pwd   = out_q.pll_pwd;
    assign pll_rst   = out_q.pll_rst;
    assign sys_rst   = out_q.sys_rst;
    assign pll_ok    = out_q.pll_ok;
    assign lock_fail = out_q.lock_fail;
    assign lock_lost = out_q.lock_lost;

`ifdef PLL_SUPV_LOSS_CNT_EN
    // Survives restart so firmware can see lifetime loss history; only rst clears it.
    always_ff @(posedge clkin1) begin
        if (rst)
            loss_cnt <= 8'd0;
        else if (lost_evt && (loss_cnt != 8'hFF))
            loss_cnt <= loss_cnt + 8'd1;
    end
`else
    // No loss history kept in this build.
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: nominal bring-up, loss in RUN, STABLE glitch,
// mid-operation reset, timeout/FAIL, restart and simultaneous-event cases.
module tb_pll_lock_supervisor;
    import pll_lock_supervisor_pkg::*;

    logic       clkin1 = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_pwd, pll_rst, sys_rst, pll_ok, lock_fail, lock_lost;
    logic [1:0] retry_cnt;
`ifdef PLL_SUPV_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // {pll_pwd, pll_rst, sys_rst, pll_ok, lock_fail, lock_lost}
    localparam logic [31:0] V_PWD  = 32'b111000;
    localparam logic [31:0] V_RST  = 32'b011000;
    localparam logic [31:0] V_WAIT = 32'b001000;
    localparam logic [31:0] V_RUN  = 32'b000100;
    localparam logic [31:0] V_FAIL = 32'b111010;
    localparam logic [31:0] V_LOST = 32'b111001;

    always #5 clkin1 = ~clkin1;

    pll_lock_supervisor dut (
        .clkin1    (clkin1),
        .rst       (rst),
        .lock      (lock),
        .restart   (restart),
        .pll_pwd   (pll_pwd),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .pll_ok    (pll_ok),
        .lock_fail (lock_fail),
        .lock_lost (lock_lost),
`ifdef PLL_SUPV_LOSS_CNT_EN
        .loss_cnt  (loss_cnt),
`endif
        .retry_cnt (retry_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {26'd0, pll_pwd, pll_rst, sys_rst, pll_ok, lock_fail, lock_lost};
    endfunction

    task automatic tick();
        @(posedge clkin1);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        // Reset and nominal bring-up
        ticks(2);
        chk("rst_outs", outs(), V_PWD);
        chk("rst_retry", 32'(retry_cnt), 32'd0);
        rst = 1'b0;
        ticks(2);
        chk("pwd_hold", outs(), V_PWD);
        tick();
        chk("pwd_fall", outs(), V_RST);
        ticks(2);
        chk("rst_hold", outs(), V_RST);
        tick();
        chk("rst_fall", outs(), V_WAIT);
        ticks(24);
        lock = 1'b1;
        tick();                 // sampling edge: the 1st of the 67
        ticks(65);
        chk("ok_early", outs(), V_WAIT);
        tick();                 // 67th edge
        chk("ok_rise", outs(), V_RUN);
        chk("nom_retry", 32'(retry_cnt), 32'd0);

        // Loss of lock in RUN
        ticks(200);
        chk("run_hold", outs(), V_RUN);
        lock = 1'b0;
        ticks(2);
        chk("lost_pre", outs(), V_RUN);
        tick();
        chk("lost_pulse", outs(), V_LOST);
`ifdef PLL_SUPV_LOSS_CNT_EN
        chk("loss_cnt", 32'(loss_cnt), 32'd1);
`endif
        lock = 1'b1;
        tick();
        chk("lost_clear", outs(), V_PWD);
        ticks(69);
        chk("rerun_early", outs(), V_WAIT);
        tick();
        chk("rerun_ok", outs(), V_RUN);

        // Glitch while qualifying
        lock = 1'b0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(10);
        lock = 1'b1;
        ticks(40);
        lock = 1'b0;
        ticks(2);
        chk("gl_still_stable", 32'(dut.state), 32'(ST_STABLE));
        lock = 1'b1;
        tick();
        chk("gl_back_wait", 32'(dut.state), 32'(ST_WAIT_LOCK));
        chk("gl_retry", 32'(retry_cnt), 32'd0);
        tick();
        chk("gl_wait2", 32'(dut.state), 32'(ST_WAIT_LOCK));
        tick();
        chk("gl_requal", 32'(dut.state), 32'(ST_STABLE));
        ticks(63);
        chk("gl_ok_early", outs(), V_WAIT);
        tick();
        chk("gl_ok_rise", outs(), V_RUN);
        chk("gl_retry2", 32'(retry_cnt), 32'd0);

        // Mid-operation reset: in RUN, then in STABLE
        rst = 1'b1;
        tick();
        chk("mrst_run_outs", outs(), V_PWD);
        chk("mrst_run_sync", 32'(dut.lock_s), 32'd0);
        rst = 1'b0;
        ticks(27);
        chk("mrst_in_stable", 32'(dut.state), 32'(ST_STABLE));
        rst = 1'b1;
        tick();
        chk("mrst_stb_outs", outs(), V_PWD);
        chk("mrst_stb_sync", 32'(dut.lock_s), 32'd0);
        chk("mrst_stb_state", 32'(dut.state), 32'(ST_PWD));
        rst = 1'b0;
        lock = 1'b0;
        ticks(3);
        chk("mrst_reseq", outs(), V_RST);

        // Timeout path: four attempts of 3+3+2500 cycles, then FAIL
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            ticks(2505);
            chk("to_wait", outs(), V_WAIT);
            chk("to_retry_pre", 32'(retry_cnt), 32'(a - 1));
            tick();
            chk("to_retry", 32'(retry_cnt), 32'(a));
            chk("to_pwd", outs(), V_PWD);
        end
        ticks(2505);
        chk("fail_pre", outs(), V_WAIT);
        tick();
        chk("fail_outs", outs(), V_FAIL);
        chk("fail_retry", 32'(retry_cnt), 32'd3);
        ticks(100);
        chk("fail_sticky", outs(), V_FAIL);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_outs", outs(), V_PWD);
        chk("restart_retry", 32'(retry_cnt), 32'd0);

        // restart coinciding with a timeout
        ticks(2506);
        chk("sim_retry1", 32'(retry_cnt), 32'd1);
        ticks(2505);
        chk("sim_pre", outs(), V_WAIT);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("sim_retry", 32'(retry_cnt), 32'd0);
        chk("sim_outs", outs(), V_PWD);
        ticks(2);
        chk("sim_pwd_hold", outs(), V_PWD);
        tick();
        chk("sim_pwd_fall", outs(), V_RST);

        // rst together with restart
        rst = 1'b1;
        restart = 1'b1;
        tick();
        rst = 1'b0;
        restart = 1'b0;
        chk("rr_outs", outs(), V_PWD);
        chk("rr_state", 32'(dut.state), 32'(ST_PWD));
        chk("rr_retry", 32'(retry_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
